// File: rtl/timer_defs.sv
// Shared definitions for the timer/counter group: FSM state encodings and
// the count-mode encodings used by the down-counter timer.
package timer_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer. It counts a software-loaded value down to
// terminal count in one-shot or periodic (auto-reload) mode. It emits a
// one-cycle registered terminal-count pulse.
module down_counter_timer
  import timer_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  output logic [WIDTH-1:0] counter_out,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] counter_q, counter_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic             mode_q, mode_n;
  logic             done_q, done_n;
  logic             tc_q, tc_n;

  // Next-state and datapath decode; priority is load > abort > start > count.
  always_comb begin
    // NOTE: every signal gets a default before the priority chain, so no
    // path leaves one unassigned and no latch is inferred.
    state_n   = state_q;
    counter_n = counter_q;
    reload_n  = reload_q;
    mode_n    = mode_q;
    done_n    = done_q;
    tc_n      = 1'b0;

    if (load) begin
      reload_n  = load_value;
      counter_n = load_value;
      state_n   = ST_IDLE;
      done_n    = 1'b0;
    end else if (abort && state_q == ST_RUN) begin
      // The count freezes where it is; abort outside RUN falls through.
      state_n = ST_IDLE;
    end else if (start && reload_q != ZERO) begin
      // Restart from the reload register; a coincident tc is dropped.
      counter_n = reload_q;
      mode_n    = mode;
      done_n    = 1'b0;
      state_n   = ST_RUN;
    end else if (state_q == ST_RUN && enable) begin
      if (counter_q == ONE) begin
        tc_n = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          // Reloading directly from 1 gives a period of exactly reload_q.
          counter_n = reload_q;
        end else begin
          counter_n = ZERO;
          state_n   = ST_EXPIRED;
          done_n    = 1'b1;
        end
      end else if (counter_q != ZERO) begin
        counter_n = counter_q - ONE;
      end
    end
  end

  // Single state register for FSM and datapath, with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= ZERO;
      reload_q  <= ZERO;
      mode_q    <= MODE_ONESHOT;
      done_q    <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_n;
      counter_q <= counter_n;
      reload_q  <= reload_n;
      mode_q    <= mode_n;
      done_q    <= done_n;
      tc_q      <= tc_n;
    end
  end

  assign counter_out = counter_q;
  assign busy        = (state_q == ST_RUN);
  assign tc_pulse    = tc_q;
  assign done        = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer (WIDTH=4). It runs directed
// scenarios and then random traffic. Every edge is checked against a
// behavioural model that tracks the count, reload value, mode, run flag,
// done flag and tc pulse.
module tb_down_counter_timer;

  localparam int WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset, enable, load, start, abort, mode;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] counter_out;
  logic             busy, tc_pulse, done;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int m_cnt, m_reload;
  bit m_mode, m_run, m_done, m_tc;

  // Observation helpers for the directed scenarios.
  int tc_seen;
  int step_no;
  int last_tc_step;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .counter_out(counter_out),
    .busy       (busy),
    .tc_pulse   (tc_pulse),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, following the behavioural rules.
  task automatic model_edge();
    m_tc = 1'b0;
    if (reset) begin
      m_cnt = 0; m_reload = 0; m_mode = 1'b0; m_run = 1'b0; m_done = 1'b0;
    end else if (load) begin
      m_reload = int'(load_value);
      m_cnt    = m_reload;
      m_run    = 1'b0;
      m_done   = 1'b0;
    end else if (abort && m_run) begin
      m_run = 1'b0;
    end else if (start && m_reload != 0) begin
      m_cnt  = m_reload;
      m_mode = mode;
      m_done = 1'b0;
      m_run  = 1'b1;
    end else if (m_run && enable) begin
      if (m_cnt == 1) begin
        m_tc = 1'b1;
        if (m_mode) m_cnt = m_reload;
        else begin
          m_cnt  = 0;
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end else if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  // Drive one cycle's inputs, clock it, and compare all outputs to the model.
  task automatic step(input bit rst, input bit ld, input int lv, input bit st,
                      input bit ab, input bit md, input bit en);
    reset = rst; load = ld; load_value = lv[WIDTH-1:0];
    start = st; abort = ab; mode = md; enable = en;
    model_edge();
    @(posedge clock);
    #1;
    step_no++;
    if (tc_pulse === 1'b1) begin
      tc_seen++;
      last_tc_step = step_no;
    end
    check("model_count", 32'(counter_out), 32'(m_cnt));
    check("model_busy",  32'(busy),        32'(m_run));
    check("model_tc",    32'(tc_pulse),    32'(m_tc));
    check("model_done",  32'(done),        32'(m_done));
  endtask

  task automatic mark();
    tc_seen = 0;
    step_no = 0;
    last_tc_step = -1;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_value = '0; start = 1'b0;
    abort = 1'b0; mode = 1'b0; enable = 1'b0;
    mark();

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_count", 32'(counter_out), 32'd0);
    check("reset_busy",  32'(busy),        32'd0);
    check("reset_done",  32'(done),        32'd0);

    // One-shot: load 5 gives the sequence 5,4,3,2,1,0, with tc on the 0.
    step(0, 1, 5, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    check("oneshot_first", 32'(counter_out), 32'd5);
    check("oneshot_busy",  32'(busy),        32'd1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      check("oneshot_seq", 32'(counter_out), 32'(4 - k));
      check("oneshot_tc",  32'(tc_pulse),    32'(k == 4));
    end
    check("oneshot_done", 32'(done), 32'd1);
    check("oneshot_idle", 32'(busy), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("expired_hold", 32'(counter_out), 32'd0);
    check("expired_done", 32'(done),        32'd1);

    // Reset mid-count at counter_out=5.
    step(0, 1, 9, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 1);
    check("midcount_pre", 32'(counter_out), 32'd5);
    step(1, 0, 0, 0, 0, 0, 1);
    check("midreset_count", 32'(counter_out), 32'd0);
    check("midreset_busy",  32'(busy),        32'd0);
    check("midreset_tc",    32'(tc_pulse),    32'd0);

    // Periodic: load 3 and run 9 enabled cycles. This gives 3 pulses spaced 3 apart.
    step(0, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    mark();
    for (int k = 0; k < 9; k++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      check("periodic_busy", 32'(busy), 32'd1);
      check("periodic_seq",  32'(counter_out), 32'(2 - (k % 3) + ((k % 3) == 2 ? 3 : 0)));
    end
    check("periodic_pulses", 32'(tc_seen), 32'd3);

    // Enable gating: one-shot load 4 with enable alternating 0/1. tc comes 8 cycles after start.
    step(0, 1, 4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    mark();
    for (int k = 1; k <= 10; k++) step(0, 0, 0, 0, 0, 0, (k % 2) == 0);
    check("gate_pulses",  32'(tc_seen),      32'd1);
    check("gate_tc_step", 32'(last_tc_step), 32'd8);

    // Start on the terminal cycle reloads the count and suppresses tc.
    step(0, 1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    check("start_at_tc_count", 32'(counter_out), 32'd2);
    check("start_at_tc_tc",    32'(tc_pulse),    32'd0);

    // A load during RUN returns the FSM to IDLE with the new value.
    step(0, 1, 9, 0, 0, 0, 1);
    check("load_in_run_count", 32'(counter_out), 32'd9);
    check("load_in_run_busy",  32'(busy),        32'd0);

    // Abort freezes the count.
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("abort_frozen", 32'(counter_out), 32'd8);
    check("abort_idle",   32'(busy),        32'd0);

    // Full-scale periodic period: load 15 gives one tc every 15 enabled cycles.
    step(0, 1, 15, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    mark();
    for (int k = 0; k < 30; k++) step(0, 0, 0, 0, 0, 0, 1);
    check("max_period_pulses", 32'(tc_seen),      32'd2);
    check("max_period_last",   32'(last_tc_step), 32'd30);
    check("max_period_reload", 32'(counter_out),  32'd15);

    // A start with reload 0 is ignored.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 1);
    check("zero_start_busy",  32'(busy),        32'd0);
    check("zero_start_count", 32'(counter_out), 32'd0);
    check("zero_start_tc",    32'(tc_pulse),    32'd0);

    // Random traffic checked edge-by-edge against the model.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 8,
           int'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 75);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
